// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory arbiter slice.
//   WORD_W       default width of addresses, data words and RAM load/store
//   ramstate_t   RAM handshake status returned by the RAM model
//   arb_state_t  memory arbiter FSM states
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IGRANT  = 2'd1,
    DRGRANT = 2'd2,
    DWGRANT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter that tracks how many consecutive dcache grants have been
// issued while an icache fetch was waiting.
//   clk     clock
//   rst     synchronous active-high reset (count -> 0)
//   inc     count one more dcache grant (ignored once saturated)
//   clr     clear the count (takes precedence over inc)
//   at_max  count has reached MAX; icache must win the next grant
module arb_starve_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    at_max = (count == W'(MAX));
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port between the icache read channel and the dcache
// read/write channel. Each access is one RAM transaction; data has fixed
// priority (write > read > fetch) but a starvation counter forces an icache
// grant after STARVE_MAX consecutive dcache grants with a fetch pending.
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         icache read request / address
//   iwait, iload        icache completion (low one cycle) / read data
//   dREN, dWEN          dcache read / write request (write wins)
//   daddr, dstore       dcache address / write data
//   dwait, dload        dcache completion (low one cycle) / read data
//   ramREN, ramWEN      RAM strobes (decoded from state only)
//   ramaddr, ramstore   RAM address / write data, latched at grant
//   ramload, ramstate   RAM read data / handshake status
//   mem_err             sticky RAM error flag, cleared only by RST
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W     = cpu_types_pkg::WORD_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              mem_err
);

  arb_state_t state, next_state;

  logic starve_at_max;
  logic starve_inc;
  logic starve_clr;
  logic force_i;
  logic take_dw;
  logic take_dr;
  logic take_i;
  logic ram_done;

  // Arbitration decision, only acted upon while IDLE.
  always_comb begin
    force_i    = iREN && starve_at_max;
    take_dw    = dWEN && !force_i;
    take_dr    = dREN && !dWEN && !force_i;
    take_i     = iREN && !take_dw && !take_dr;
    starve_inc = (state == IDLE) && (take_dw || take_dr) && iREN;
    starve_clr = (state == IDLE) && (take_i || !iREN);
    ram_done   = (ramstate == ACCESS) || (ramstate == ERROR);
  end

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (CLK),
    .rst    (RST),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Every grant returns through IDLE, which guarantees the
  // one-cycle gap between RAM transactions.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (take_dw) begin
          next_state = DWGRANT;
        end else if (take_dr) begin
          next_state = DRGRANT;
        end else if (take_i) begin
          next_state = IGRANT;
        end
      end
      IGRANT, DRGRANT, DWGRANT: begin
        if (ram_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address/data latch at grant, and the sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ramaddr  <= '0;
      ramstore <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (take_dw || take_dr) begin
          ramaddr  <= daddr;
          ramstore <= dstore;
        end else if (take_i) begin
          ramaddr <= iaddr;
        end
      end
      if ((state != IDLE) && (ramstate == ERROR)) begin
        mem_err <= 1'b1;
      end
    end
  end

  // Output decode. Strobes depend on state only; a hit additionally needs the
  // owner to still hold its request, so a dropped request completes silently.
  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    iwait  = 1'b1;
    dwait  = 1'b1;
    iload  = '0;
    dload  = '0;
    case (state)
      IGRANT: begin
        ramREN = 1'b1;
        if ((ramstate == ACCESS) && iREN) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DRGRANT: begin
        ramREN = 1'b1;
        if ((ramstate == ACCESS) && dREN) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      DWGRANT: begin
        ramWEN = 1'b1;
        if ((ramstate == ACCESS) && dWEN) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule
